// File: rtl/pattern_ser_pkg.sv
// -----------------------------------------------------------------------------
// pattern_ser_pkg
// Shared types and defaults for the pattern serializer slice.
//   ser_state_e     : serializer FSM states (S_PARITY only reachable when the
//                     PATTERN_SER_PARITY_EN build option is defined)
//   DEF_WIDTH       : default bits per word
//   DEF_FIFO_DEPTH  : default word FIFO depth
//   even_parity()   : XOR-reduce of a word, zero-extended to PAR_MAX_W bits
// -----------------------------------------------------------------------------
package pattern_ser_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_PARITY
  } ser_state_e;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  // Widest word the parity helper accepts; callers zero-extend into it.
  localparam int PAR_MAX_W = 64;

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/pattern_word_fifo.sv
// -----------------------------------------------------------------------------
// pattern_word_fifo
// Synchronous word FIFO with asynchronous active-high reset. Read data is
// the head entry, valid whenever empty_o is low (show-ahead).
// Ports:
//   clk_i, rst_i     clock / async active-high reset
//   push_i, wdata_i  write strobe and data (ignored when full)
//   pop_i            read strobe (ignored when empty)
//   rdata_o          head-of-queue word
//   full_o, empty_o  occupancy flags
//   level_o          number of stored words, 0..DEPTH
// -----------------------------------------------------------------------------
module pattern_word_fifo
  import pattern_ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its inputs, regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // meaningful, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pattern_serializer.sv
// -----------------------------------------------------------------------------
// pattern_serializer
// Buffers parallel words in a small FIFO and shifts each one out MSB-first,
// one bit per cycle in which bit_en_i is high. data_o/valid_o are registered
// and feed the pattern detector's data_i/valid_i directly.
// Build option: define PATTERN_SER_PARITY_EN to append an even-parity bit
// after every word (WIDTH must then be <= 64).
// Ports:
//   clk_i, rst_i                 clock / async active-high reset
//   word_i, word_valid_i         parallel word and its valid
//   word_ready_o                 FIFO can take a word (0 during reset)
//   bit_en_i                     pacing enable
//   data_o, valid_o              serial bit stream
//   busy_o                       FSM not idle
//   fifo_level_o                 FIFO occupancy
//   words_sent_o                 completed-word counter, wraps
// -----------------------------------------------------------------------------
module pattern_serializer
  import pattern_ser_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [WIDTH-1:0]              word_i,
  input  logic                          word_valid_i,
  output logic                          word_ready_o,
  input  logic                          bit_en_i,
  output logic                          data_o,
  output logic                          valid_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [CNT_W-1:0]              words_sent_o
);

  localparam int BIT_W = $clog2(WIDTH+1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH);

  ser_state_e        state_q;
  logic [WIDTH-1:0]  shift_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic              data_q, valid_q;
  logic [CNT_W-1:0]  words_q, words_d;

  logic              fifo_full, fifo_empty, fifo_push, pop;
  logic [WIDTH-1:0]  fifo_rdata;

  assign word_ready_o = !fifo_full && !rst_i;
  assign fifo_push    = word_valid_i && word_ready_o;

  pattern_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i (word_i),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  // A word is "done" on the enabled edge after its final bit was presented;
  // that same edge may load the next word so the stream has no gap.
  logic word_done;

  // NOTE: every signal assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    word_done = 1'b0;
    if (bit_en_i) begin
`ifdef PATTERN_SER_PARITY_EN
      word_done = (state_q == S_PARITY);
`else
      word_done = (state_q == S_SHIFT) && (bit_cnt_q == LAST_BIT);
`endif
    end
    pop     = bit_en_i && !fifo_empty && ((state_q == S_IDLE) || word_done);
    words_d = words_q + CNT_W'(word_done);
  end

  // The shift register rotates rather than shifts: after WIDTH-1 rotations it
  // still holds a permutation of the word, so its parity equals the word's.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= 1'b0;
      valid_q   <= 1'b0;
      words_q   <= '0;
    end else begin
      words_q <= words_d;
      if (!bit_en_i) begin
        valid_q <= 1'b0;
      end else if (pop) begin
        shift_q   <= {fifo_rdata[WIDTH-2:0], fifo_rdata[WIDTH-1]};
        data_q    <= fifo_rdata[WIDTH-1];
        valid_q   <= 1'b1;
        bit_cnt_q <= BIT_W'(1);
        state_q   <= S_SHIFT;
      end else begin
        unique case (state_q)
          S_SHIFT: begin
            if (bit_cnt_q != LAST_BIT) begin
              shift_q   <= {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};
              data_q    <= shift_q[WIDTH-1];
              valid_q   <= 1'b1;
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end else begin
`ifdef PATTERN_SER_PARITY_EN
              data_q  <= even_parity(PAR_MAX_W'(shift_q));
              valid_q <= 1'b1;
              state_q <= S_PARITY;
`else
              valid_q <= 1'b0;
              state_q <= S_IDLE;
`endif
            end
          end
          S_PARITY: begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign busy_o       = (state_q != S_IDLE);
  assign words_sent_o = words_q;

endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
- Upstream stage of the pattern detector. Accepts parallel words on a valid/ready handshake and buffers them in a small FIFO.
- Shifts each word out MSB-first, one bit per enabled cycle, on data_o/valid_o. These outputs wire directly to the detector's data_i/valid_i.
- Gives the bench and system a word-level interface to a bit-serial detector, with pacing control and status.

Parameters:
- WIDTH, 8, bits per input word (>=2).
- FIFO_DEPTH, 4, word FIFO entries (power of two, >=2).
- CNT_W, 16, width of the sent-word counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- word_i  in  WIDTH  parallel word to serialize.
- word_valid_i  in  1  word_i valid.
- word_ready_o  out  1  FIFO can accept a word.
- bit_en_i  in  1  pacing enable; a bit is emitted only in cycles where it is high.
- data_o  out  1  serial bit, feeds detector data_i.
- valid_o  out  1  data_o valid, feeds detector valid_i.
- busy_o  out  1  a word is in flight (FSM not IDLE).
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- words_sent_o  out  CNT_W  count of fully emitted words, wraps.

Behaviour:
- Reset (async assert, sync to clk_i on deassert):
  - All outputs 0: data_o, valid_o, busy_o, fifo_level_o, words_sent_o.
  - word_ready_o is 0 while rst_i is high and 1 after.
  - FIFO flushed, FSM to IDLE, bit counter 0.
- Handshake:
  - Word accepted at an edge where word_valid_i && word_ready_o.
  - word_ready_o = !full. It is registered-state based and ignores a same-cycle pop.
  - No FIFO bypass: a word pushed into an empty FIFO can first be popped on the following edge.
  - Simultaneous push and pop leaves the level unchanged.
- FSM states IDLE, SHIFT (and PARITY when the optional feature is enabled).
  - IDLE: at an edge with FIFO non-empty && bit_en_i:
    - pop the word into the shift register;
    - data_o <= word[WIDTH-1], valid_o <= 1, bit counter <= 1;
    - go to SHIFT.
  - SHIFT: at an edge with bit_en_i and bit counter < WIDTH:
    - data_o <= next bit (MSB-first), valid_o <= 1, counter++.
  - SHIFT, last bit emitted (counter == WIDTH) with bit_en_i:
    - words_sent_o++;
    - if FIFO non-empty, pop the next word and emit its MSB in this same edge (no gap);
    - otherwise valid_o <= 0 and go to IDLE.
  - Any edge with bit_en_i=0: valid_o <= 0. Shift register, counter and state hold. data_o holds its last value.
- Latency: first bit valid on the second edge after the acceptance edge. A WIDTH-bit word occupies WIDTH enabled cycles.
- Counter: words_sent_o wraps from all-ones to 0.
- busy_o = (state != IDLE).
- Reset mid-word: the partial word and all FIFO contents are discarded, valid_o drops immediately (async), and the counter is cleared.

Optional Feature:
- Macro: PATTERN_SER_PARITY_EN.
- Defined: after the last data bit, the FSM enters PARITY.
  - It emits one extra bit on the next enabled cycle: even parity = XOR of all WIDTH bits, with valid_o=1.
  - words_sent_o increments at the parity bit, not at the last data bit.
  - The next word (if any) is popped at the parity edge.
  - Each word occupies WIDTH+1 enabled cycles.
- Undefined: no PARITY state; behaviour exactly as above.

Decomposition:
- Package pattern_ser_pkg holds:
  - the state enum ser_state_e {S_IDLE, S_SHIFT, S_PARITY};
  - default localparams for WIDTH and FIFO_DEPTH;
  - a function for even parity.
- One sub-module, pattern_word_fifo: synchronous FIFO with async active-high reset.
  - Parameters WIDTH and DEPTH.
  - Ports: push/pop, full/empty, level.
  - Pointers are one bit wider than the address to distinguish full from empty.
- pattern_serializer contains only the FSM, shift register and counters.

Test Plan:
- Single word, WIDTH=8, 8'hB5 accepted at edge k, bit_en_i=1 -> valid_o high for edges k+2..k+9, data_o = 1,0,1,1,0,1,0,1; then valid_o=0; words_sent_o=1.
- Back-to-back 8'hB5 then 8'h0F -> 16 consecutive valid bits, no gap: 10110101 00001111; words_sent_o=2.
- bit_en_i=0, push 5 words -> 4 accepted, fifo_level_o=4, word_ready_o=0 on the 5th. Raise bit_en_i -> all 4 words drain in order, level returns to 0.
- Toggle bit_en_i 1,0,1,0... during 8'hB5 -> valid_o low on disabled cycles, bit sequence still 10110101, each bit emitted exactly once.
- Assert rst_i after 3 bits of a word with 2 queued -> valid_o=0 immediately, level=0, counter=0. After release, a new 8'h81 serializes as 10000001.
- With PATTERN_SER_PARITY_EN: 8'hB5 -> 9 valid bits, 9th = 1. With 8'h0F -> 9th = 0. With CNT_W=2 and 5 words -> words_sent_o ends at 1 (wrap).
